// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Brief    : Shared encodings and command record for the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = 4;

  localparam int          ST_W    = 2;
  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_REQ  = 2'd1;
  localparam logic [1:0]  ST_WAIT = 2'd2;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  // Transaction held for the whole memory handshake.
  typedef struct packed {
    logic              owner;
    logic              wr;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pick
// Brief    : Combinational grant selection between fetch and load/store.
//            MEM_ARB_ROUND_ROBIN_EN alternates ties; otherwise data wins.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic i_inst_req,
  input  logic i_data_req,
  input  logic i_last_grant,
  output logic o_owner,
  output logic o_grant_valid
);

  assign o_grant_valid = i_inst_req | i_data_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    if (i_inst_req && i_data_req) begin
      o_owner = ~i_last_grant;
    end else if (i_data_req) begin
      o_owner = OWNER_DATA;
    end else begin
      o_owner = OWNER_INST;
    end
  end
`else
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;
  assign o_owner = i_data_req ? OWNER_DATA : OWNER_INST;
`endif

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-port (fetch, load/store) arbiter onto one memory port with a
//            single outstanding transaction. Optional: MEM_ARB_ROUND_ROBIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,

  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  output logic              mem_req,
  output logic              mem_wr,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_state_next;
  mem_cmd_t        r_cmd;
  mem_cmd_t        w_cmd_next;
  logic            w_pick_owner;
  logic            w_grant_valid;
  logic            w_last_grant;
  logic            w_accept;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  // Starts at inst so the first tie after reset goes to data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= OWNER_INST;
    end else if (w_accept) begin
      r_last_grant <= w_pick_owner;
    end
  end

  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = OWNER_INST;
`endif

  mem_arb_pick u_pick (
    .i_inst_req    (inst_req),
    .i_data_req    (data_req),
    .i_last_grant  (w_last_grant),
    .o_owner       (w_pick_owner),
    .o_grant_valid (w_grant_valid)
  );

  assign w_accept = (r_state == ST_IDLE) && w_grant_valid;

  always_comb begin
    w_cmd_next = '0;
    w_cmd_next.owner = w_pick_owner;
    if (w_pick_owner == OWNER_DATA) begin
      w_cmd_next.wr    = data_wr;
      w_cmd_next.wstrb = data_wstrb;
      w_cmd_next.addr  = data_addr;
      w_cmd_next.wdata = data_wdata;
    end else begin
      w_cmd_next.addr  = inst_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd <= '0;
    end else if (w_accept) begin
      r_cmd <= w_cmd_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_grant_valid) w_state_next = ST_REQ;
      ST_REQ:  if (mem_addr_ok)   w_state_next = ST_WAIT;
      ST_WAIT: if (mem_data_ok)   w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Accept is gated by reset so nothing is granted while reset is held.
  always_comb begin
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    mem_req      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid && !reset) begin
          if (w_pick_owner == OWNER_DATA) data_addr_ok = 1'b1;
          else                            inst_addr_ok = 1'b1;
        end
      end
      ST_REQ:  mem_req = 1'b1;
      ST_WAIT: begin
        if (mem_data_ok) begin
          if (r_cmd.owner == OWNER_DATA) data_data_ok = 1'b1;
          else                           inst_data_ok = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign mem_wr     = r_cmd.wr;
  assign mem_wstrb  = r_cmd.wstrb;
  assign mem_addr   = r_cmd.addr;
  assign mem_wdata  = r_cmd.wdata;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Randomised scoreboard bench for mem_arbiter against a
//            transaction-level reference model (MEM_ARB_ROUND_ROBIN_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int NCYC = 4000;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          a_i, a_d, d_i, d_d, mreq;
    bit          wr;
    logic [3:0]  ws;
    logic [31:0] addr, wdata, rdata;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: one outstanding transaction, tracked by whether the
  // memory has taken it yet. Owner 1 means the load/store port.
  bit          m_txn, m_sent, m_owner, m_last;
  bit          m_wr;
  logic [3:0]  m_ws;
  logic [31:0] m_addr, m_wdata;
  bit          i_pend, d_pend;
  int          rst_cnt;

  function automatic bit pick(input bit ri, input bit rd);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (ri && rd) return !m_last;
`endif
    return rd;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_txn = 0; m_sent = 0; m_last = 0;
    end else if (!m_txn) begin
      if (inst_req || data_req) begin
        m_owner = pick(inst_req, data_req);
        m_last  = m_owner;
        m_txn   = 1;
        m_sent  = 0;
        if (m_owner) begin
          m_wr = data_wr; m_ws = data_wstrb; m_addr = data_addr; m_wdata = data_wdata;
          d_pend = 0;
        end else begin
          m_wr = 0; m_ws = 4'h0; m_addr = inst_addr; m_wdata = 32'h0;
          i_pend = 0;
        end
      end
    end else if (!m_sent) begin
      if (mem_addr_ok) m_sent = 1;
    end else if (mem_data_ok) begin
      m_txn = 0;
    end
  endtask

  task automatic drive(input int cyc);
    int p_i, p_d, p_a, p_r;
    if (cyc < 200)       begin p_i = 40;  p_d = 0;   p_a = 100; p_r = 100; end
    else if (cyc < 1000) begin p_i = 100; p_d = 100; p_a = 100; p_r = 100; end
    else                 begin p_i = 50;  p_d = 50;  p_a = 45;  p_r = 45;  end

    if (rst_cnt > 0) begin
      reset = 1; rst_cnt--;
    end else begin
      reset = 0;
      if (cyc == 600 || (cyc >= 1000 && m_txn && m_sent && $urandom_range(99) < 4)) begin
        reset = 1; rst_cnt = 1;
      end
    end

    if (!i_pend) begin
      inst_req = ($urandom_range(99) < p_i);
      if (inst_req) begin
        inst_addr = $urandom() & 32'hFFFF_FFFC;
        i_pend = 1;
      end
    end
    if (!d_pend) begin
      data_req = ($urandom_range(99) < p_d);
      if (data_req) begin
        data_wr    = $urandom_range(1);
        data_wstrb = 4'($urandom_range(15));
        data_addr  = $urandom() & 32'hFFFF_FFFC;
        data_wdata = $urandom();
        d_pend = 1;
      end
    end

    mem_addr_ok = ($urandom_range(99) < p_a);
    mem_data_ok = ($urandom_range(99) < p_r);
    mem_rdata   = $urandom();
  endtask

  task automatic push_expected();
    exp_t e;
    bit   own;
    own     = pick(inst_req, data_req);
    e.a_i   = !reset && !m_txn && inst_req && !own;
    e.a_d   = !reset && !m_txn && data_req && own;
    e.mreq  = !reset && m_txn && !m_sent;
    e.d_i   = !reset && m_txn && m_sent && mem_data_ok && !m_owner;
    e.d_d   = !reset && m_txn && m_sent && mem_data_ok && m_owner;
    e.wr    = m_wr;
    e.ws    = m_ws;
    e.addr  = m_addr;
    e.wdata = m_wdata;
    e.rdata = mem_rdata;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("inst_addr_ok", 32'(inst_addr_ok), 32'(e.a_i));
        chk("data_addr_ok", 32'(data_addr_ok), 32'(e.a_d));
        chk("inst_data_ok", 32'(inst_data_ok), 32'(e.d_i));
        chk("data_data_ok", 32'(data_data_ok), 32'(e.d_d));
        chk("mem_req", 32'(mem_req), 32'(e.mreq));
        if (e.mreq) begin
          chk("mem_wr", 32'(mem_wr), 32'(e.wr));
          chk("mem_wstrb", 32'(mem_wstrb), 32'(e.ws));
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_wdata", mem_wdata, e.wdata);
        end
        chk("inst_rdata", inst_rdata, e.rdata);
        chk("data_rdata", data_rdata, e.rdata);
      end
    end
  end

  initial begin
    reset = 1;
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    m_txn = 0; m_sent = 0; m_owner = 0; m_last = 0;
    m_wr = 0; m_ws = 0; m_addr = 0; m_wdata = 0;
    i_pend = 0; d_pend = 0;
    rst_cnt = 2;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      model_edge();
      #1;
      drive(cyc);
      push_expected();
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
